// File: rtl/crop_video_axis_tx_pkg.sv
// Shared state encodings, skid entry tag layout and helpers for the crop core
// AXIS master output stage.
package crop_video_axis_tx_pkg;

    localparam logic [1:0] ST_INIT_WAIT = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_STREAM    = 2'd2;
    localparam logic [1:0] ST_DRAIN     = 2'd3;

    typedef logic [1:0] tx_state_t;

    // Framing tags that travel with each pixel through the skid buffer.
    typedef struct packed {
        logic tlast;
        logic tuser;
    } skid_tag_t;

    localparam int TAG_W = $bits(skid_tag_t);

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int entry_w(input int data_w);
        return data_w + TAG_W;
    endfunction

endpackage

// File: rtl/crop_video_axis_skid_buf.sv
// Two-entry register skid buffer; head entry drives the output directly so the
// consumer sees registered data and push readiness never depends on pop.
module crop_video_axis_skid_buf #(
    parameter int ENTRY_W = 34
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_din,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_dout,
    output logic               o_full,
    output logic               o_empty
);

    logic [ENTRY_W-1:0] r_head;
    logic [ENTRY_W-1:0] r_tail;
    logic [1:0]         r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_dout  = r_head;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    // Occupancy unchanged; the head advances and the new entry lands behind it.
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end else begin
                        r_head <= i_din;
                    end
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_din;
                    end else begin
                        r_tail <= i_din;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/crop_video_axis_master_tx.sv
// AXIS video master output stage of the crop core: frames cropped pixels with
// tuser (start of frame) / tlast (end of line) and buffers against backpressure.
module crop_video_axis_master_tx
    import crop_video_axis_tx_pkg::*;
#(
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_START_COUNT = 32,
    parameter int DIM_W                  = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DIM_W-1:0]                    cfg_width,
    input  logic [DIM_W-1:0]                    cfg_height,
    input  logic                                in_tvalid,
    output logic                                in_tready,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   in_tdata,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tlast,
    output logic                                m00_axis_tuser,
    output logic                                frame_done,
    output logic                                cfg_err
);

    localparam int STRB_W  = strb_w(C_M00_AXIS_TDATA_WIDTH);
    localparam int ENTRY_W = entry_w(C_M00_AXIS_TDATA_WIDTH);
    localparam logic [31:0] START_TC = (C_M00_AXIS_START_COUNT > 0) ?
                                       32'(C_M00_AXIS_START_COUNT - 1) : 32'd0;
    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    tx_state_t          r_state;
    logic [31:0]        r_start_cnt;
    logic [DIM_W-1:0]   r_width;
    logic [DIM_W-1:0]   r_height;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic [DIM_W-1:0]   r_out_row;
    logic               r_cfg_err;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_last_col;
    logic               w_last_row;
    skid_tag_t          w_in_tag;
    skid_tag_t          w_out_tag;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;

    assign in_tready  = (r_state == ST_STREAM) && !w_full;
    assign w_accept   = in_tvalid && in_tready;
    assign w_pop      = !w_empty && m00_axis_tready;
    assign w_last_col = (r_col == r_width - ONE);
    assign w_last_row = (r_row == r_height - ONE);

    always_comb begin
        w_in_tag       = '0;
        w_in_tag.tlast = w_last_col;
        w_in_tag.tuser = (r_col == '0) && (r_row == '0);
    end

    assign w_din = {in_tdata, w_in_tag};

    crop_video_axis_skid_buf #(
        .ENTRY_W (ENTRY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_out_tag       = skid_tag_t'(w_dout[TAG_W-1:0]);
    assign m00_axis_tvalid = !w_empty;
    assign m00_axis_tdata  = w_dout[ENTRY_W-1:TAG_W];
    assign m00_axis_tlast  = w_out_tag.tlast;
    assign m00_axis_tuser  = w_out_tag.tuser;
    assign m00_axis_tstrb  = {STRB_W{1'b1}};
    assign frame_done      = r_frame_done;
    assign cfg_err         = r_cfg_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT_WAIT;
            r_start_cnt <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT_WAIT: begin
                    if (r_start_cnt == START_TC) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_start_cnt <= r_start_cnt + 32'd1;
                    end
                end
                ST_IDLE: begin
                    if ((cfg_width == '0) || (cfg_height == '0)) begin
                        r_cfg_err <= 1'b1;
                    end else begin
                        r_cfg_err <= 1'b0;
                        r_width   <= cfg_width;
                        r_height  <= cfg_height;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_state   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row) begin
                                r_row   <= '0;
                                r_state <= ST_DRAIN;
                            end else begin
                                r_row <= r_row + ONE;
                            end
                        end else begin
                            r_col <= r_col + ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_INIT_WAIT;
            endcase
        end
    end

    // Output-side line count: the last tlast beat of the frame to leave the buffer ends it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_row    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_pop && w_out_tag.tlast) begin
                if (r_out_row == r_height - ONE) begin
                    r_out_row    <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_out_row <= r_out_row + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_crop_video_axis_master_tx.sv
// Scoreboard bench for crop_video_axis_master_tx: pixels accepted by the DUT push
// their expected framing into a queue, AXIS handshakes pop and compare.
module tb_crop_video_axis_master_tx;

    localparam int DW    = 32;
    localparam int DIM_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [DIM_W-1:0]  cfg_width;
    logic [DIM_W-1:0]  cfg_height;
    logic              in_tvalid;
    logic              in_tready;
    logic [DW-1:0]     in_tdata;
    logic              m00_axis_tvalid;
    logic              m00_axis_tready;
    logic [DW-1:0]     m00_axis_tdata;
    logic [DW/8-1:0]   m00_axis_tstrb;
    logic              m00_axis_tlast;
    logic              m00_axis_tuser;
    logic              frame_done;
    logic              cfg_err;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
        logic          eof;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int first_cyc = 0;
    bit first_seen = 1'b0;
    int beats = 0;
    int fd_count = 0;
    bit fd_pend = 1'b0;
    bit stall_prev = 1'b0;
    logic [DW+1:0] prev_beat = '0;

    always #5 clk = ~clk;

    crop_video_axis_master_tx #(
        .C_M00_AXIS_TDATA_WIDTH (DW),
        .C_M00_AXIS_START_COUNT (32),
        .DIM_W                  (DIM_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .in_tvalid       (in_tvalid),
        .in_tready       (in_tready),
        .in_tdata        (in_tdata),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tuser  (m00_axis_tuser),
        .frame_done      (frame_done),
        .cfg_err         (cfg_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pops, stall stability and frame_done timing.
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            fd_pend    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check_eq("frame_done", frame_done, fd_pend);
            if (frame_done) fd_count++;
            fd_pend = 1'b0;
            if (stall_prev) begin
                check_eq("stall_tvalid", m00_axis_tvalid, 1);
                check_eq("stall_beat", {m00_axis_tdata, m00_axis_tlast, m00_axis_tuser}, prev_beat);
            end
            if (m00_axis_tvalid && !first_seen) begin
                first_seen = 1'b1;
                first_cyc  = cyc;
            end
            if (m00_axis_tvalid && m00_axis_tready) begin
                beats++;
                check_eq("tstrb", m00_axis_tstrb, 4'hF);
                if (sb.size() == 0) begin
                    check_eq("unexpected_beat", m00_axis_tdata, 'x);
                end else begin
                    e = sb.pop_front();
                    check_eq("tdata", m00_axis_tdata, e.d);
                    check_eq("tlast", m00_axis_tlast, e.l);
                    check_eq("tuser", m00_axis_tuser, e.u);
                    if (e.eof) fd_pend = 1'b1;
                end
            end
            stall_prev = m00_axis_tvalid && !m00_axis_tready;
            prev_beat  = {m00_axis_tdata, m00_axis_tlast, m00_axis_tuser};
        end
    end

    task automatic send_frame(input logic [DW-1:0] base, input int w, input int h);
        bit abort;
        bit done;
        int t;
        abort = 1'b0;
        for (int r = 0; r < h && !abort; r++) begin
            for (int c = 0; c < w && !abort; c++) begin
                in_tdata  = base + DW'(r * w + c);
                in_tvalid = 1'b1;
                done = 1'b0;
                t = 0;
                while (!done && !abort) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                    end else if (in_tready) begin
                        sb.push_back('{d: in_tdata, l: (c == w - 1), u: (r == 0 && c == 0),
                                       eof: (c == w - 1 && r == h - 1)});
                        done = 1'b1;
                    end else begin
                        t++;
                        if (t > 300) begin
                            check_eq("in_accept_timeout", in_tready, 1);
                            abort = 1'b1;
                        end
                    end
                end
                if (!abort) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || m00_axis_tvalid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_sb_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target);
        int t;
        t = 0;
        while (beats < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("beat_wait", beats, target);
    endtask

    task automatic release_and_check_init();
        rst        = 1'b0;
        rel_cyc    = cyc;
        first_seen = 1'b0;
        repeat (33) begin
            @(negedge clk);
            check_eq("init_in_tready", in_tready, 0);
            check_eq("init_tvalid", m00_axis_tvalid, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0;
        rst             = 1'b1;
        in_tvalid       = 1'b0;
        in_tdata        = '0;
        m00_axis_tready = 1'b1;
        cfg_width       = 12'd4;
        cfg_height      = 12'd2;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", m00_axis_tvalid, 0);
        check_eq("rst_in_tready", in_tready, 0);
        check_eq("rst_tdata", m00_axis_tdata, 0);
        check_eq("rst_tlast", m00_axis_tlast, 0);
        check_eq("rst_tuser", m00_axis_tuser, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_cfg_err", cfg_err, 0);
        check_eq("rst_tstrb", m00_axis_tstrb, 4'hF);

        // Start count with input already valid, then the basic 4x2 frame.
        in_tvalid = 1'b1;
        in_tdata  = 32'h10;
        release_and_check_init();
        send_frame(32'h10, 4, 2);
        wait_drain();
        check_eq("start_latency_ok", (first_cyc - rel_cyc) >= 34, 1);
        check_eq("fd_count_basic", fd_count, 1);

        // Backpressure: 5 stalled cycles after the second beat of the frame.
        b0 = beats;
        fork
            send_frame(32'hA0, 4, 2);
            begin
                wait_beats(b0 + 2);
                @(posedge clk);
                #1;
                m00_axis_tready = 1'b0;
                repeat (4) @(negedge clk);
                check_eq("bp_in_tready", in_tready, 0);
                check_eq("bp_tvalid_held", m00_axis_tvalid, 1);
                @(negedge clk);
                @(posedge clk);
                #1;
                m00_axis_tready = 1'b1;
            end
        join
        wait_drain();
        check_eq("fd_count_bp", fd_count, 2);

        // Geometry change mid-frame is ignored until the next frame.
        fork
            send_frame(32'h20, 4, 2);
            begin
                repeat (3) @(posedge clk);
                #1;
                cfg_width  = 12'd3;
                cfg_height = 12'd1;
            end
        join
        wait_drain();
        check_eq("fd_count_geo1", fd_count, 3);
        send_frame(32'h30, 3, 1);
        cfg_width = 12'd0;
        wait_drain();
        check_eq("fd_count_geo2", fd_count, 4);

        // Invalid geometry: nothing accepted, error latched.
        in_tvalid = 1'b1;
        in_tdata  = 32'hEE;
        repeat (5) @(negedge clk);
        check_eq("inv_cfg_err", cfg_err, 1);
        check_eq("inv_in_tready", in_tready, 0);
        check_eq("inv_tvalid", m00_axis_tvalid, 0);
        @(posedge clk);
        #1;
        cfg_width  = 12'd2;
        cfg_height = 12'd1;
        send_frame(32'h40, 2, 1);
        cfg_width  = 12'd4;
        cfg_height = 12'd2;
        wait_drain();
        check_eq("inv_cfg_err_clr", cfg_err, 0);
        check_eq("fd_count_inv", fd_count, 5);

        // Reset after three output beats of an 8-beat frame.
        b0 = beats;
        fork
            send_frame(32'h50, 4, 2);
            begin
                wait_beats(b0 + 3);
                @(posedge clk);
                #1;
                rst = 1'b1;
                #1;
                check_eq("mid_rst_tvalid", m00_axis_tvalid, 0);
                check_eq("mid_rst_in_tready", in_tready, 0);
                check_eq("mid_rst_tdata", m00_axis_tdata, 0);
                check_eq("mid_rst_tuser", m00_axis_tuser, 0);
            end
        join
        sb.delete();
        in_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        release_and_check_init();
        send_frame(32'h60, 4, 2);
        wait_drain();
        check_eq("restart_latency_ok", (first_cyc - rel_cyc) >= 34, 1);
        check_eq("fd_count_restart", fd_count, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
